// File: rtl/system1_pio_arbiter.sv
// Round-robin arbiter letting two Avalon-MM masters share one PIO slave port.
// Optional grant locking is enabled by defining SYSTEM1_PIO_ARB_LOCK_EN.
module system1_pio_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_chipselect,
    input  logic              m0_write_n,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
`ifdef SYSTEM1_PIO_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_chipselect,
    input  logic              m1_write_n,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata
);

    localparam int unsigned LOCK_CNT_W = 3;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state, state_nxt;
    // grant also serves as last_grant: both always hold the most recent winner
    logic                grant, grant_nxt;
    logic [ADDR_W-1:0]   s_address_nxt;
    logic                s_chipselect_nxt;
    logic                s_write_n_nxt;
    logic [DATA_W-1:0]   s_writedata_nxt;
    logic [1:0]          req;
    logic                gsel;
    logic                ack0, ack1;

`ifdef SYSTEM1_PIO_ARB_LOCK_EN
    logic                  lock_hold, lock_hold_nxt;
    logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nxt;
`endif

    assign req = {m1_chipselect, m0_chipselect};

    // State and slave-side output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= 1'b1;
            s_address    <= '0;
            s_chipselect <= 1'b0;
            s_write_n    <= 1'b1;
            s_writedata  <= '0;
`ifdef SYSTEM1_PIO_ARB_LOCK_EN
            lock_hold    <= 1'b0;
            lock_cnt     <= '0;
`endif
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            s_address    <= s_address_nxt;
            s_chipselect <= s_chipselect_nxt;
            s_write_n    <= s_write_n_nxt;
            s_writedata  <= s_writedata_nxt;
`ifdef SYSTEM1_PIO_ARB_LOCK_EN
            lock_hold    <= lock_hold_nxt;
            lock_cnt     <= lock_cnt_nxt;
`endif
        end
    end

    // Arbitration and next-state logic
    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant;
        s_address_nxt    = s_address;
        s_chipselect_nxt = 1'b0;
        s_write_n_nxt    = 1'b1;
        s_writedata_nxt  = s_writedata;
        gsel             = 1'b0;
`ifdef SYSTEM1_PIO_ARB_LOCK_EN
        lock_hold_nxt    = lock_hold;
        lock_cnt_nxt     = lock_cnt;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    gsel = (req == 2'b11) ? ~grant : req[1];
`ifdef SYSTEM1_PIO_ARB_LOCK_EN
                    // A locked winner keeps the port until its 8th consecutive grant
                    if (lock_hold && req[grant]) begin
                        if (lock_cnt == LOCK_CNT_W'(7) && req[~grant])
                            gsel = ~grant;
                        else
                            gsel = grant;
                    end
                    if (gsel == grant)
                        lock_cnt_nxt = (lock_cnt == LOCK_CNT_W'(7)) ? lock_cnt
                                                                     : lock_cnt + LOCK_CNT_W'(1);
                    else
                        lock_cnt_nxt = '0;
`endif
                    grant_nxt        = gsel;
                    s_address_nxt    = gsel ? m1_address   : m0_address;
                    s_write_n_nxt    = gsel ? m1_write_n   : m0_write_n;
                    s_writedata_nxt  = gsel ? m1_writedata : m0_writedata;
                    s_chipselect_nxt = 1'b1;
                    state_nxt        = ACCESS;
                end
            end
            ACCESS: begin
`ifdef SYSTEM1_PIO_ARB_LOCK_EN
                lock_hold_nxt = grant ? m1_lock : m0_lock;
`endif
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ack0 = (state == ACCESS) && !grant;
    assign ack1 = (state == ACCESS) &&  grant;

    assign m0_waitrequest = m0_chipselect & ~ack0;
    assign m1_waitrequest = m1_chipselect & ~ack1;
    assign m0_readdata    = ack0 ? s_readdata : '0;
    assign m1_readdata    = ack1 ? s_readdata : '0;

endmodule

// File: tb/tb_system1_pio_arbiter.sv
// Directed bench for system1_pio_arbiter with a small PIO slave model.
// Lock scenario is included when SYSTEM1_PIO_ARB_LOCK_EN is defined.
module tb_system1_pio_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  m0_address, m1_address;
    logic        m0_chipselect, m1_chipselect;
    logic        m0_write_n, m1_write_n;
    logic [31:0] m0_writedata, m1_writedata;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [31:0] pio_out;
`ifdef SYSTEM1_PIO_ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    system1_pio_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_chipselect  (m0_chipselect),
        .m0_write_n     (m0_write_n),
        .m0_writedata   (m0_writedata),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
`ifdef SYSTEM1_PIO_ARB_LOCK_EN
        .m0_lock        (m0_lock),
        .m1_lock        (m1_lock),
`endif
        .m1_address     (m1_address),
        .m1_chipselect  (m1_chipselect),
        .m1_write_n     (m1_write_n),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_chipselect   (s_chipselect),
        .s_write_n      (s_write_n),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO model: register at address 0, other addresses read as zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pio_out <= 32'd0;
        else if (s_chipselect && !s_write_n && s_address == 2'd0)
            pio_out <= s_writedata;
    end
    assign s_readdata = (s_address == 2'd0) ? pio_out : 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_address = 2'd0; m0_chipselect = 1'b0; m0_write_n = 1'b1; m0_writedata = 32'd0;
        m1_address = 2'd0; m1_chipselect = 1'b0; m1_write_n = 1'b1; m1_writedata = 32'd0;
`ifdef SYSTEM1_PIO_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_masters();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_masters();
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_cs",    32'(s_chipselect), 32'd0);
        check("rst_s_wn",    32'(s_write_n),    32'd1);
        check("rst_s_addr",  32'(s_address),    32'd0);
        check("rst_s_wdata", s_writedata,       32'd0);
        m0_chipselect = 1'b1;
        #1;
        check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("rst_m0_rd",   m0_readdata,         32'd0);
        m0_chipselect = 1'b0;
        #1;
        reset = 1'b0;

        // m0 lone write
        m0_address = 2'd0; m0_write_n = 1'b0; m0_writedata = 32'hA5A50001; m0_chipselect = 1'b1;
        #1;
        check("t1_c0_wait", 32'(m0_waitrequest), 32'd1);
        check("t1_c0_cs",   32'(s_chipselect),   32'd0);
        tick();
        check("t1_c1_cs",    32'(s_chipselect),   32'd1);
        check("t1_c1_wn",    32'(s_write_n),      32'd0);
        check("t1_c1_wdata", s_writedata,         32'hA5A50001);
        check("t1_c1_wait",  32'(m0_waitrequest), 32'd0);
        tick();
        m0_chipselect = 1'b0;
        check("t1_c2_cs",  32'(s_chipselect), 32'd0);
        check("t1_c2_pio", pio_out,           32'hA5A50001);
        tick();
        check("t1_c3_cs",  32'(s_chipselect), 32'd0);

        // simultaneous requests
        do_reset();
        m0_write_n = 1'b0; m0_writedata = 32'h11; m0_chipselect = 1'b1;
        m1_write_n = 1'b0; m1_writedata = 32'h22; m1_chipselect = 1'b1;
        tick();
        check("t2_c1_w0",    32'(m0_waitrequest), 32'd0);
        check("t2_c1_w1",    32'(m1_waitrequest), 32'd1);
        check("t2_c1_wdata", s_writedata,         32'h11);
        tick();
        m0_chipselect = 1'b0;
        check("t2_c2_pio",   pio_out,             32'h11);
        check("t2_c2_w1",    32'(m1_waitrequest), 32'd1);
        tick();
        check("t2_c3_w1",    32'(m1_waitrequest), 32'd0);
        check("t2_c3_wdata", s_writedata,         32'h22);
        tick();
        m1_chipselect = 1'b0;
        check("t2_c4_pio",   pio_out,             32'h22);

        // continuous contention alternates
        do_reset();
        m0_write_n = 1'b0; m0_writedata = 32'h100; m0_chipselect = 1'b1;
        m1_write_n = 1'b0; m1_writedata = 32'h200; m1_chipselect = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            logic odd, e0, e1;
            tick();
            odd = (c % 2) == 1;
            e0  = odd && ((c / 2) % 2 == 0);
            e1  = odd && ((c / 2) % 2 == 1);
            check($sformatf("t3_c%0d_w0", c), 32'(m0_waitrequest), 32'(!e0));
            check($sformatf("t3_c%0d_w1", c), 32'(m1_waitrequest), 32'(!e1));
            check($sformatf("t3_c%0d_cs", c), 32'(s_chipselect),   32'(odd));
        end
        idle_masters();
        tick();

        // m1 write then two reads
        do_reset();
        m1_address = 2'd0; m1_write_n = 1'b0; m1_writedata = 32'h12345678; m1_chipselect = 1'b1;
        tick();
        check("t4_c1_w1",  32'(m1_waitrequest), 32'd0);
        check("t4_c1_rd0", m0_readdata,         32'd0);
        tick();
        m1_write_n = 1'b1;
        check("t4_c2_rd1", m1_readdata,         32'd0);
        tick();
        check("t4_c3_rd1", m1_readdata,         32'h12345678);
        check("t4_c3_rd0", m0_readdata,         32'd0);
        check("t4_c3_w1",  32'(m1_waitrequest), 32'd0);
        tick();
        m1_address = 2'd1;
        check("t4_c4_rd1", m1_readdata,         32'd0);
        tick();
        check("t4_c5_w1",  32'(m1_waitrequest), 32'd0);
        check("t4_c5_rd1", m1_readdata,         32'd0);
        check("t4_c5_rd0", m0_readdata,         32'd0);
        tick();
        idle_masters();

        // reset during m1 access
        do_reset();
        m1_address = 2'd0; m1_write_n = 1'b0; m1_writedata = 32'hDEAD; m1_chipselect = 1'b1;
        tick();
        check("t5_c1_cs", 32'(s_chipselect), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_cs",  32'(s_chipselect),   32'd0);
        check("t5_rst_wn",  32'(s_write_n),      32'd1);
        check("t5_rst_w1",  32'(m1_waitrequest), 32'd1);
        check("t5_rst_rd1", m1_readdata,         32'd0);
        m0_write_n = 1'b0; m0_writedata = 32'h55; m0_chipselect = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("t5_rel_w0",    32'(m0_waitrequest), 32'd0);
        check("t5_rel_w1",    32'(m1_waitrequest), 32'd1);
        check("t5_rel_wdata", s_writedata,         32'h55);
        idle_masters();
        tick();

`ifdef SYSTEM1_PIO_ARB_LOCK_EN
        // m0 lock: 8 consecutive m0 grants, then m1
        do_reset();
        m0_lock = 1'b1;
        m0_write_n = 1'b0; m0_chipselect = 1'b1;
        m1_write_n = 1'b0; m1_chipselect = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            logic odd, e0, e1;
            tick();
            odd = (c % 2) == 1;
            e0  = odd && (((c - 1) / 2) < 8);
            e1  = odd && (((c - 1) / 2) >= 8);
            check($sformatf("t6_c%0d_w0", c), 32'(m0_waitrequest), 32'(!e0));
            check($sformatf("t6_c%0d_w1", c), 32'(m1_waitrequest), 32'(!e1));
        end
        idle_masters();
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/system1_pio_arbiter.md
Name: system1_pio_arbiter

Overview:
- Two-master arbiter sharing one Avalon-MM PIO slave port (2-bit address, chipselect, write_n, writedata, readdata) in the system1 Nios II subsystem.
- Master 0 is typically the Nios data master; master 1 is a hardware sequencer.
- Round-robin grant, one slave access per grant, and Avalon waitrequest back-pressure to the losing or pending master.

Parameters:
- DATA_W, 32, data width of writedata and readdata on all ports
- ADDR_W, 2, slave word-address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- m0_address  in  ADDR_W  master 0 word address
- m0_chipselect  in  1  master 0 request; held until waitrequest low
- m0_write_n  in  1  master 0 write strobe, active-low; high = read
- m0_writedata  in  DATA_W  master 0 write data
- m0_readdata  out  DATA_W  master 0 read data, valid in ack cycle
- m0_waitrequest  out  1  master 0 stall
- m1_address, m1_chipselect, m1_write_n, m1_writedata, m1_readdata, m1_waitrequest: same as m0_* for master 1
- s_address  out  ADDR_W  to PIO address
- s_chipselect  out  1  to PIO chipselect
- s_write_n  out  1  to PIO write_n
- s_writedata  out  DATA_W  to PIO writedata
- s_readdata  in  DATA_W  from PIO readdata (combinational, zero wait)

Behaviour:
- Reset is asynchronous and active-high; clock is clk. While reset is high:
  - state = IDLE, last_grant = 1 (so m0 wins first)
  - s_chipselect = 0, s_write_n = 1, s_address = 0, s_writedata = 0
- FSM has two states: IDLE and ACCESS.
- IDLE:
  - Sample m0_chipselect and m1_chipselect.
  - If none is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the master != last_grant.
  - On grant, register grant and last_grant <= grant. Register s_address, s_write_n and s_writedata from the granted master, set s_chipselect <= 1, and go to ACCESS.
- ACCESS: lasts exactly one cycle. s_chipselect is high for that cycle only. Then go to IDLE, with s_chipselect <= 0 and s_write_n <= 1.
- Ack: mN_ack = (state == ACCESS) && (grant == N).
- Waitrequest: mN_waitrequest = mN_chipselect & ~mN_ack (combinational).
  - The reset value follows chipselect, i.e. stall.
- Read data: mN_readdata = mN_ack ? s_readdata : 0 (combinational pass-through). It is 0 outside the ack cycle and during reset.
- Latency: request seen in IDLE at cycle N, slave access and ack in cycle N+1. Throughput is at most one transfer per 2 cycles.
- Continuous requests from both masters alternate m0, m1, m0, ... No master waits more than 4 cycles after its request is sampled.
- A master that drops chipselect while in IDLE is not granted. A master that drops chipselect during ACCESS still has its slave access completed; the ack is ignored.
- Writes to the slave occur only in ACCESS (s_chipselect high with s_write_n low). No spurious slave strobes in any other state.
- Reset mid-ACCESS:
  - s_chipselect falls immediately (asynchronous) and the access is aborted.
  - After release, arbitration restarts with m0 priority.
- The address is forwarded unmodified. Read data for unmapped addresses is whatever the slave returns (0 for the PIO).

Optional Feature:
- Macro: SYSTEM1_PIO_ARB_LOCK_EN
- When defined:
  - Adds inputs m0_lock and m1_lock (1 bit each).
  - If the granted master has lock high in its ACCESS cycle, the next arbitration in IDLE grants the same master whenever it requests, overriding round-robin. The other master waits.
  - A lock is held at most 8 consecutive grants. A 3-bit counter resets on grant change or on reset; at count 8 the grant is forced to the other master if it is requesting.
- When undefined: no lock ports, no counter, pure round-robin as above.

Test Plan:
- m0 writes 0xA5A50001 to addr 0 alone, after reset -> s_chipselect high exactly cycle 1 with s_write_n = 0; m0_waitrequest low in cycle 1; PIO out_port = 0xA5A50001.
- m0 and m1 request together after reset (m0 writes 0x11, m1 writes 0x22) -> m0 acked cycle 1, m1 acked cycle 3; final PIO value 0x22.
- Both masters hold chipselect for 8 transfers -> acks alternate m0, m1, m0, m1, ... at cycles 1, 3, 5, 7, ...; no cycle has two acks.
- m1 writes 0x12345678 to addr 0, then reads addr 0 and addr 1 -> m1_readdata = 0x12345678 in the first ack cycle, 0 in the second; m0_readdata = 0 throughout.
- Assert reset during an m1 ACCESS cycle -> s_chipselect is 0 before the next clk edge. After release with both masters requesting, m0 is granted first.
- With SYSTEM1_PIO_ARB_LOCK_EN: m0_lock = 1 and both masters request continuously -> m0 gets 8 consecutive grants, then m1 is granted; with the macro undefined the same stimulus alternates.
